wb_stage_mc: RTL and testbench
==============================

# wb_stage_mc

Parametrised multi-lane write-back stage for the five-stage core. It registers up to LANES retiring results from MEM each cycle, drives the register-file write ports directly, and supports flush alongside the stall-vector pipeline control. It serialises all retiring writes, one per cycle and in program order, onto the single debug trace port through a small queue. When the queue cannot accept a full bundle it raises a stall request.

## Interface
- LANES, 2: retiring lanes per cycle (1..4). Lane 0 is the oldest.
- PC_OFFSET, 32'h4: subtracted from the registered pc on the debug port.
- DBG_DEPTH, 4: debug trace queue entries. Must be a power of two and ≥ LANES.
- STALL_W, 6: stall vector width.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Asserting it (0) clears all state immediately.
- stall  in  STALL_W  pipeline stall vector. Bit 4 is the WB-input stage and bit 5 is the stage after it. Stop=1, NoStop=0.
- flush  in  1  discard the incoming bundle at this edge.
- mem_to_wb_bus  in  LANES*70  per lane {pc[31:0], we, waddr[4:0], wdata[31:0]}. Lane i occupies bits [70*i+69 : 70*i].
- wb_to_rf_bus  out  LANES*38  per lane {we, waddr[4:0], wdata[31:0]}, same lane ordering.
- stallreq_wb  out  1  1 when queue free space < LANES.
- debug_wb_pc  out  32  head entry pc − PC_OFFSET; 0 when the queue is empty.
- debug_wb_rf_wen  out  4  {4{1}} when the queue is non-empty, else 0.
- debug_wb_rf_wnum  out  5  head waddr; 0 when empty.
- debug_wb_rf_wdata  out  32  head wdata; 0 when empty.
- debug_overflow  out  1  sticky: a write was dropped because the queue lacked space.

## Operation
- Pipeline register (LANES×70 bits), evaluated in priority order at each edge:
  - flush=1: load all zeros.
  - stall[4]=Stop and stall[5]=NoStop: load zeros (bubble).
  - stall[4]=NoStop: load mem_to_wb_bus. This is the only case that counts as a "new load".
  - Otherwise: hold.
- wb_to_rf_bus is taken combinationally from the register, so every lane writes the register file while the register holds it.
- Trace enqueue happens only on a new-load edge.
  - Each incoming lane with we=1 pushes {pc, waddr, wdata} in ascending lane order.
  - Lanes with we=0 are not pushed.
  - Hold, bubble and flush edges push nothing, so a held bundle is never traced twice.
- Trace dequeue:
  - While the queue is non-empty, the head drives the debug outputs.
  - The head pops at the next edge.
  - Push and pop in the same edge are both applied: count' = count + pushes − pop.
- Pointers are log2(DBG_DEPTH) bits and wrap modulo DBG_DEPTH. count is log2(DBG_DEPTH)+1 bits.
- stallreq_wb = (DBG_DEPTH − count) < LANES. It is combinational from count only, not from the pop in progress.
- Overflow: if a new load pushes k writes and free space (counting the same-edge pop) is < k:
  - the oldest writes that fit are kept;
  - the rest are dropped;
  - debug_overflow is set until reset.
  - The control unit is responsible for preventing this.
- PC arithmetic is 32-bit modulo.

## Timing
- Reset values: register 0, queue empty, count 0, all outputs 0, stallreq_wb 0 (given DBG_DEPTH ≥ LANES), debug_overflow 0.
- Latency, RF path: a bundle loaded at edge N is on wb_to_rf_bus in cycle N.
- Latency, debug path: with an empty queue, the first write of a bundle loaded at edge N appears on the debug port in cycle N. Write j of that bundle appears in cycle N+j.
- Trace throughput is 1 write per cycle.
- stallreq_wb reflects count after each edge, in the same cycle.
- Reset asserted mid-operation clears the register and queue without waiting for a clock edge. Any queued trace entries are lost.

## Test plan
- Reset: rst=0 → all outputs 0 with no clock needed. Release rst, no input → debug_wb_rf_wen stays 0.
- Single write, LANES=2: lane0 {pc=0xBFC00004, we=1, waddr=3, wdata=0x11}, lane1 we=0, stall=0 → same cycle debug_wb_pc=0xBFC00000, wnum=3, wdata=0x11. Next cycle wen=0.
- Dual write: lane0 {pc=0x104, waddr=1, wdata=0xA}, lane1 {pc=0x108, waddr=2, wdata=0xB} → cycle N shows pc 0x100/waddr 1, cycle N+1 shows pc 0x104/waddr 2. Both lanes are on wb_to_rf_bus in cycle N.
- Hold and bubble:
  - stall[5:4]=2'b11 for 3 cycles → register held, no extra trace entries.
  - stall[5:4]=2'b01 → register zeroed, no push.
- Flush with stall[4]=NoStop and valid input → register zero, queue unchanged.
- Backpressure, DBG_DEPTH=4:
  - two consecutive dual-write loads, then stall[4]=Stop → stallreq_wb=1 once count>2;
  - queue drains one entry per cycle, and stallreq_wb returns to 0 when count=2.
  - Forcing a third load while full → only fitting writes kept, debug_overflow=1.

Source files
------------

// File: rtl/wb_stage_mc.sv
// Multi-lane write-back stage: registers retiring lanes, drives the RF write ports and
// serialises every retiring write, in program order, onto the single debug trace port.
module wb_stage_mc #(
    parameter int          LANES     = 2,
    parameter logic [31:0] PC_OFFSET = 32'h4,
    parameter int          DBG_DEPTH = 4,
    parameter int          STALL_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [LANES*70-1:0]   mem_to_wb_bus,
    output logic [LANES*38-1:0]   wb_to_rf_bus,
    output logic                  stallreq_wb,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata,
    output logic                  debug_overflow
);

    localparam int PW = (DBG_DEPTH > 1) ? $clog2(DBG_DEPTH) : 1;
    localparam int CW = $clog2(DBG_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DBG_DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } entry_t;

    logic [LANES*70-1:0] pipe_q, pipe_d;
    entry_t              q_mem_q [DBG_DEPTH];
    entry_t              q_mem_d [DBG_DEPTH];
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;

    logic                new_load;
    logic                pop;
    logic [CW-1:0]       free_slots;
    logic [CW-1:0]       pushed;
    logic [PW-1:0]       wr_idx;
    entry_t              head_e;
    logic                stall_unused;

    assign stall_unused = ^stall;

    always_comb begin
        pipe_d   = pipe_q;
        new_load = 1'b0;
        if (flush) begin
            pipe_d = '0;
        end else if (stall[4] && !stall[5]) begin
            pipe_d = '0;
        end else if (!stall[4]) begin
            pipe_d   = mem_to_wb_bus;
            new_load = 1'b1;
        end
    end

    // Free space counts the head popping at this same edge; writes that do not fit are dropped
    // from the youngest lane upward so the oldest writes always survive.
    always_comb begin
        q_mem_d    = q_mem_q;
        overflow_d = overflow_q;
        pushed     = '0;
        wr_idx     = '0;
        pop        = (count_q != '0);
        free_slots = DEPTH_C - count_q + {{(CW-1){1'b0}}, pop};
        for (int i = 0; i < LANES; i++) begin
            if (new_load && mem_to_wb_bus[70*i+37]) begin
                if (pushed < free_slots) begin
                    wr_idx          = PW'((int'(tail_q) + int'(pushed)) % DBG_DEPTH);
                    q_mem_d[wr_idx] = {mem_to_wb_bus[70*i+38 +: 32],
                                       mem_to_wb_bus[70*i+32 +: 5],
                                       mem_to_wb_bus[70*i +: 32]};
                    pushed          = pushed + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
        head_d  = pop ? PW'((int'(head_q) + 1) % DBG_DEPTH) : head_q;
        tail_d  = PW'((int'(tail_q) + int'(pushed)) % DBG_DEPTH);
        count_d = count_q + pushed - {{(CW-1){1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DBG_DEPTH; i++) begin
                q_mem_q[i] <= '0;
            end
        end else begin
            pipe_q     <= pipe_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            q_mem_q    <= q_mem_d;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wb_to_rf_bus[38*i +: 38] = pipe_q[70*i +: 38];
        end
    end

    always_comb begin
        head_e            = q_mem_q[head_q];
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (count_q != '0) begin
            debug_wb_pc       = head_e.pc - PC_OFFSET;
            debug_wb_rf_wen   = 4'hF;
            debug_wb_rf_wnum  = head_e.waddr;
            debug_wb_rf_wdata = head_e.wdata;
        end
    end

    assign stallreq_wb    = (DEPTH_C - count_q) < LANES_C;
    assign debug_overflow = overflow_q;

endmodule

// File: tb/tb_wb_stage_mc.sv
// Randomised bench for wb_stage_mc: a reference model queues expected trace entries at each edge,
// and a monitor on the falling edge compares the debug port, RF bus and status flags.
module tb_wb_stage_mc;

    localparam int          LANES     = 2;
    localparam int          DBG_DEPTH = 4;
    localparam logic [31:0] PC_OFFSET = 32'h4;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_t;

    logic                clk;
    logic                rst;
    logic [5:0]          stall;
    logic                flush;
    logic [LANES*70-1:0] mem_to_wb_bus;
    logic [LANES*38-1:0] wb_to_rf_bus;
    logic                stallreq_wb;
    logic [31:0]         debug_wb_pc;
    logic [3:0]          debug_wb_rf_wen;
    logic [4:0]          debug_wb_rf_wnum;
    logic [31:0]         debug_wb_rf_wdata;
    logic                debug_overflow;

    int     errors = 0;
    int     checks = 0;
    trace_t sb[$];
    logic [LANES*70-1:0] reg_exp = '0;
    logic   ovf_exp = 1'b0;
    logic   seen_stallreq = 1'b0;

    wb_stage_mc #(
        .LANES(LANES), .PC_OFFSET(PC_OFFSET), .DBG_DEPTH(DBG_DEPTH), .STALL_W(6)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_to_wb_bus(mem_to_wb_bus), .wb_to_rf_bus(wb_to_rf_bus),
        .stallreq_wb(stallreq_wb), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata), .debug_overflow(debug_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [69:0] make_lane(input logic [31:0] pc, input logic we,
                                              input logic [4:0] waddr, input logic [31:0] wdata);
        return {pc, we, waddr, wdata};
    endfunction

    function automatic logic [LANES*38-1:0] rf_view(input logic [LANES*70-1:0] r);
        logic [LANES*38-1:0] v;
        for (int i = 0; i < LANES; i++) v[38*i +: 38] = r[70*i +: 38];
        return v;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [5:0] st, input logic fl, input logic [LANES*70-1:0] bus);
        @(posedge clk);
        #2;
        stall         = st;
        flush         = fl;
        mem_to_wb_bus = bus;
    endtask

    // Reference model: every write of a newly loaded bundle becomes one trace entry while
    // the queue (already reduced by the head popped at the previous falling edge) has room.
    always @(posedge clk) begin
        if (rst) begin
            if (!flush && !stall[4]) begin
                for (int i = 0; i < LANES; i++) begin
                    logic [69:0] ln;
                    ln = mem_to_wb_bus[70*i +: 70];
                    if (ln[37]) begin
                        if (sb.size() < DBG_DEPTH) sb.push_back('{ln[69:38] - PC_OFFSET, ln[36:32], ln[31:0]});
                        else ovf_exp = 1'b1;
                    end
                end
            end
            if (flush) reg_exp = '0;
            else if (stall[4] && !stall[5]) reg_exp = '0;
            else if (!stall[4]) reg_exp = mem_to_wb_bus;
        end
    end

    // Monitor: the head shown this cycle pops at the next edge, so it leaves the scoreboard now.
    always @(negedge clk) begin
        if (rst) begin
            check_output("stallreq", 128'(stallreq_wb), 128'((DBG_DEPTH - sb.size()) < LANES));
            check_output("overflow", 128'(debug_overflow), 128'(ovf_exp));
            check_output("rf_bus", 128'(wb_to_rf_bus), 128'(rf_view(reg_exp)));
            if (stallreq_wb) seen_stallreq = 1'b1;
            if (sb.size() != 0) begin
                trace_t e;
                e = sb.pop_front();
                check_output("dbg_wen", 128'(debug_wb_rf_wen), 128'(4'hF));
                check_output("dbg_pc", 128'(debug_wb_pc), 128'(e.pc));
                check_output("dbg_wnum", 128'(debug_wb_rf_wnum), 128'(e.waddr));
                check_output("dbg_wdata", 128'(debug_wb_rf_wdata), 128'(e.wdata));
            end else begin
                check_output("dbg_idle", {debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata}, '0);
            end
        end
    end

    task automatic check_all_zero(input string name);
        check_output({name, "_dbg"}, {debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata}, '0);
        check_output({name, "_flags"}, {stallreq_wb, debug_overflow}, '0);
        check_output({name, "_rf"}, 128'(wb_to_rf_bus), '0);
    endtask

    initial begin
        logic [LANES*70-1:0] dual;
        rst = 1'b1; stall = '0; flush = 1'b0; mem_to_wb_bus = '0;
        #1 rst = 1'b0;
        #1 check_all_zero("reset");
        #2 rst = 1'b1;
        repeat (2) apply_stimulus(6'b000000, 1'b0, '0);

        // Single write then idle
        apply_stimulus(6'b000000, 1'b0, {make_lane(32'h0, 1'b0, 5'd9, 32'h99),
                                         make_lane(32'hBFC00004, 1'b1, 5'd3, 32'h11)});
        @(posedge clk); #3;
        check_output("single_pc", 128'(debug_wb_pc), 128'(32'hBFC00000));
        check_output("single_wnum", 128'(debug_wb_rf_wnum), 128'(5'd3));
        #0 stall = '0; mem_to_wb_bus = '0;

        // Dual write, hold three cycles, then bubble
        dual = {make_lane(32'h108, 1'b1, 5'd2, 32'hB), make_lane(32'h104, 1'b1, 5'd1, 32'hA)};
        apply_stimulus(6'b000000, 1'b0, dual);
        apply_stimulus(6'b110000, 1'b0, '0);
        repeat (2) apply_stimulus(6'b110000, 1'b0, '0);
        apply_stimulus(6'b010000, 1'b0, '0);
        apply_stimulus(6'b000000, 1'b1, dual);
        repeat (3) apply_stimulus(6'b000000, 1'b0, '0);

        // Backpressure and overflow: four back-to-back dual loads into a four-entry queue
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(6'b000000, 1'b0, {make_lane(32'h200 + 32'(8*k) + 32'h4, 1'b1, 5'(2*k+1), 32'(100+2*k+1)),
                                             make_lane(32'h200 + 32'(8*k), 1'b1, 5'(2*k), 32'(100+2*k))});
        end
        apply_stimulus(6'b110000, 1'b0, '0);
        @(negedge clk); #1;
        check_output("overflow_set", 128'(debug_overflow), 128'(1'b1));
        repeat (6) apply_stimulus(6'b110000, 1'b0, '0);
        check_output("stallreq_seen", 128'(seen_stallreq), 128'(1'b1));

        // Mid-operation asynchronous reset drops queued entries
        apply_stimulus(6'b000000, 1'b0, dual);
        apply_stimulus(6'b110000, 1'b0, '0);
        @(posedge clk); #2;
        rst = 1'b0;
        sb.delete(); reg_exp = '0; ovf_exp = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk); #2;
        rst = 1'b1; stall = '0; mem_to_wb_bus = '0;

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [LANES*70-1:0] bus;
            logic [5:0] st;
            for (int i = 0; i < LANES; i++) begin
                bus[70*i +: 70] = make_lane($urandom, ($urandom_range(0, 9) < 6), 5'($urandom), $urandom);
            end
            st = 6'($urandom);
            st[4] = ($urandom_range(0, 9) < 4);
            apply_stimulus(st, ($urandom_range(0, 19) == 0), bus);
        end
        repeat (8) apply_stimulus(6'b110000, 1'b0, '0);
        @(negedge clk); #1;
        check_output("final_drain", 128'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
